// File: rtl/phit_pkg.sv
// Shared phit encoding and injector state type for the 4-bit-phit fabric.
package phit_pkg;

  localparam logic [1:0] PHIT_HEAD = 2'b11;
  localparam logic [1:0] PHIT_PAY  = 2'b10;
  localparam logic [1:0] PHIT_IDLE = 2'b00;

  typedef struct packed {
    logic [1:0] ptype;
    logic [1:0] field;
  } phit_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HEAD = 2'd2,
    ST_PAY  = 2'd3
  } inj_state_t;

endpackage

// File: rtl/packet_injector_if.sv
// Client-facing bundle of the packet injector: request, payload and router-side outputs.
// Handshakes: a transfer happens on a rising edge where valid & ready are both high;
// ready depends on injector state only, and valid must not wait on ready.
interface packet_injector_if #(
  parameter int MAX_HOPS  = 4,
  parameter int MAX_WORDS = 16
);
  logic                             req_valid;
  logic                             req_ready;
  logic [2*MAX_HOPS-1:0]            req_route;
  logic [$clog2(MAX_HOPS+1)-1:0]    req_hops;
  logic [$clog2(MAX_WORDS+1)-1:0]   req_len;
  logic                             data_valid;
  logic                             data_ready;
  logic [1:0]                       data;
  logic [3:0]                       phit;
  logic                             busy;
  logic                             err;

  modport master (
    output req_valid, req_route, req_hops, req_len, data_valid, data,
    input  req_ready, data_ready, phit, busy, err
  );

  modport slave (
    input  req_valid, req_route, req_hops, req_len, data_valid, data,
    output req_ready, data_ready, phit, busy, err
  );
endinterface

// File: rtl/payload_buf.sv
// Payload register file: written in order during LOAD, read in the same order during PAY.
module payload_buf #(
  parameter int DEPTH = 16,
  parameter int DW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Contents need no reset: every word read in PAY was written in the same packet's LOAD.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/packet_injector.sv
// Source-side injector: buffers a whole payload, then emits head phits per hop
// followed by the payload as one gap-free phit stream.
module packet_injector
  import phit_pkg::*;
#(
  parameter int MAX_HOPS  = 4,
  parameter int MAX_WORDS = 16
) (
  input  logic               clk,
  input  logic               rst,
  packet_injector_if.slave   bus,
  output inj_state_t         state_dbg
);
  localparam int HW = $clog2(MAX_HOPS + 1);
  localparam int LW = $clog2(MAX_WORDS + 1);
  localparam int RW = 2 * MAX_HOPS;

  inj_state_t      state_q, state_d;
  logic [RW-1:0]   route_q;
  logic [HW-1:0]   hops_q;
  logic [LW-1:0]   len_q;
  logic [HW-1:0]   hop_idx_q, hop_idx_d, hop_nxt;
  logic [LW-1:0]   word_cnt_q, word_cnt_d, cnt_nxt;
  phit_t           phit_q, phit_d;
  logic            err_q, err_d;
  logic            latch, buf_clr, wr_en, rd_en, req_bad;
  logic [1:0]      rd_data, next_port;

  payload_buf #(.DEPTH(MAX_WORDS), .DW(2)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .clr     (buf_clr),
    .wr_en   (wr_en),
    .wr_data (bus.data),
    .rd_en   (rd_en),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      route_q    <= '0;
      hops_q     <= '0;
      len_q      <= '0;
      hop_idx_q  <= '0;
      word_cnt_q <= '0;
      phit_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hop_idx_q  <= hop_idx_d;
      word_cnt_q <= word_cnt_d;
      phit_q     <= phit_d;
      err_q      <= err_d;
      if (latch) begin
        route_q <= bus.req_route;
        hops_q  <= bus.req_hops;
        len_q   <= bus.req_len;
      end
    end
  end

  // phit_d is the phit shown on the cycle after this edge, so transitions load it directly.
  always_comb begin
    state_d    = state_q;
    hop_idx_d  = hop_idx_q;
    word_cnt_d = word_cnt_q;
    phit_d     = '0;
    err_d      = 1'b0;
    latch      = 1'b0;
    buf_clr    = 1'b0;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    hop_nxt    = hop_idx_q + 1'b1;
    cnt_nxt    = word_cnt_q + 1'b1;
    next_port  = 2'(route_q >> {hop_nxt, 1'b0});
    req_bad    = (bus.req_hops == '0) || (bus.req_hops > HW'(MAX_HOPS)) ||
                 (bus.req_len > LW'(MAX_WORDS));
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          latch      = 1'b1;
          buf_clr    = 1'b1;
          hop_idx_d  = '0;
          word_cnt_d = '0;
          if (req_bad) begin
            err_d = 1'b1;
          end else if (bus.req_len == '0) begin
            state_d = ST_HEAD;
            phit_d  = {PHIT_HEAD, bus.req_route[1:0]};
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (bus.data_valid) begin
          wr_en      = 1'b1;
          word_cnt_d = cnt_nxt;
          if (cnt_nxt == len_q) begin
            state_d = ST_HEAD;
            phit_d  = {PHIT_HEAD, route_q[1:0]};
          end
        end
      end
      ST_HEAD: begin
        if (hop_nxt == hops_q) begin
          if (len_q != '0) begin
            state_d    = ST_PAY;
            phit_d     = {PHIT_PAY, rd_data};
            rd_en      = 1'b1;
            word_cnt_d = len_q - 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          hop_idx_d = hop_nxt;
          phit_d    = {PHIT_HEAD, next_port};
        end
      end
      ST_PAY: begin
        // word_cnt_q counts payload words still to follow the one on phit now.
        if (word_cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          phit_d     = {PHIT_PAY, rd_data};
          rd_en      = 1'b1;
          word_cnt_d = word_cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.req_ready  = (state_q == ST_IDLE);
  assign bus.data_ready = (state_q == ST_LOAD);
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.phit       = phit_q;
  assign bus.err        = err_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_packet_injector.sv
// Directed and randomized packets against a queue-based model of the expected phit stream.
module tb_packet_injector;
  import phit_pkg::*;

  localparam int MAX_HOPS  = 4;
  localparam int MAX_WORDS = 16;

  logic       clk = 1'b0;
  logic       rst;
  inj_state_t state_dbg;
  int         checks = 0;
  int         errors = 0;
  logic [1:0] words [MAX_WORDS];
  logic [3:0] exp_q [$];

  packet_injector_if #(.MAX_HOPS(MAX_HOPS), .MAX_WORDS(MAX_WORDS)) bus ();

  packet_injector #(.MAX_HOPS(MAX_HOPS), .MAX_WORDS(MAX_WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic fill_words();
    for (int i = 0; i < MAX_WORDS; i++) words[i] = 2'($urandom_range(0, 3));
  endtask

  // Called at a negedge; returns at a negedge with the DUT idle.
  task automatic run_illegal(input int hops, input int len);
    bus.req_valid = 1'b1;
    bus.req_hops  = 3'(hops);
    bus.req_len   = 5'(len);
    bus.req_route = 8'($urandom);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("illegal_err", 32'(bus.err), 32'd1);
    check("illegal_phit", 32'(bus.phit), 32'h0);
    check("illegal_req_ready", 32'(bus.req_ready), 32'd1);
    check("illegal_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    check("illegal_err_clear", 32'(bus.err), 32'd0);
    check("illegal_phit_after", 32'(bus.phit), 32'h0);
  endtask

  // gap_mode: 0 back-to-back data, 1 toggling valid, 2 random valid.
  // abort_at >= 0 asserts reset while that phit index is on the wire.
  task automatic send_packet(input int hops, input logic [7:0] route, input int len,
                             input int gap_mode, input bit keep_valid, input int abort_at);
    int got;
    int budget;
    int idx;
    logic vld;
    logic [3:0] e;
    exp_q.delete();
    for (int i = 0; i < hops; i++) exp_q.push_back({2'b11, 2'(route >> (2 * i))});
    for (int j = 0; j < len; j++) exp_q.push_back({2'b10, words[j]});

    bus.req_valid = 1'b1;
    bus.req_hops  = 3'(hops);
    bus.req_len   = 5'(len);
    bus.req_route = route;
    check("req_ready_idle", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    if (!keep_valid) bus.req_valid = 1'b0;

    got = 0;
    budget = 0;
    while (got < len && budget < 400) begin
      check("load_data_ready", 32'(bus.data_ready), 32'd1);
      check("load_phit_idle", 32'(bus.phit), 32'h0);
      check("load_busy", 32'(bus.busy), 32'd1);
      case (gap_mode)
        0:       vld = 1'b1;
        1:       vld = (budget % 2 == 0);
        default: vld = 1'($urandom_range(0, 1));
      endcase
      bus.data_valid = vld;
      bus.data       = words[got];
      @(posedge clk);
      if (vld) got++;
      @(negedge clk);
      budget++;
    end
    bus.data_valid = 1'b0;
    if (got < len) check("load_timeout", 32'(got), 32'(len));

    idx = 0;
    while (exp_q.size() > 0) begin
      if (abort_at >= 0 && idx == abort_at) begin
        bus.data_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("abort_phit_idle", 32'(bus.phit), 32'h0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_req_ready", 32'(bus.req_ready), 32'd1);
        check("abort_state", 32'(state_dbg), 32'(ST_IDLE));
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      e = exp_q.pop_front();
      check("pkt_phit", 32'(bus.phit), 32'(e));
      check("pkt_req_ready", 32'(bus.req_ready), 32'd0);
      check("pkt_data_ready", 32'(bus.data_ready), 32'd0);
      check("pkt_busy", 32'(bus.busy), 32'd1);
      bus.data_valid = 1'($urandom_range(0, 1));
      bus.data       = 2'($urandom_range(0, 3));
      @(negedge clk);
      idx++;
    end
    bus.data_valid = 1'b0;
    check("post_phit_idle", 32'(bus.phit), 32'h0);
    check("post_req_ready", 32'(bus.req_ready), 32'd1);
    check("post_busy", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_route  = '0;
    bus.req_hops   = '0;
    bus.req_len    = '0;
    bus.data_valid = 1'b0;
    bus.data       = '0;
    #1;
    check("rst_phit", 32'(bus.phit), 32'h0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_data_ready", 32'(bus.data_ready), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    rst = 1'b0;
    @(negedge clk);

    // Two hops, route 0110, payload 1,2,3: stream E D 9 A B then idle.
    words[0] = 2'd1; words[1] = 2'd2; words[2] = 2'd3;
    send_packet(2, 8'b0000_0110, 3, 0, 1'b0, -1);

    // Single hop, no payload.
    send_packet(1, 8'b0000_0011, 0, 0, 1'b0, -1);

    // Payload arriving every other cycle.
    fill_words();
    send_packet(1, 8'($urandom), 4, 1, 1'b0, -1);

    // Illegal requests.
    run_illegal(0, 3);
    run_illegal(2, MAX_WORDS + 1);
    run_illegal(MAX_HOPS + 1, 2);

    // Reset during PAY after 2 of 5 payload phits, then a clean packet.
    fill_words();
    send_packet(1, 8'b0000_0010, 5, 0, 1'b0, 1 + 2);
    fill_words();
    send_packet(3, 8'($urandom), 5, 2, 1'b0, -1);

    // Back-to-back requests with req_valid held high throughout.
    fill_words();
    send_packet(2, 8'($urandom), 2, 0, 1'b1, -1);
    send_packet(MAX_HOPS, 8'($urandom), 0, 0, 1'b1, -1);
    fill_words();
    send_packet(1, 8'($urandom), MAX_WORDS, 0, 1'b0, -1);

    // Randomized legal and illegal requests.
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        if ($urandom_range(0, 1) == 0) run_illegal(0, $urandom_range(0, MAX_WORDS));
        else run_illegal($urandom_range(1, MAX_HOPS), $urandom_range(MAX_WORDS + 1, 31));
      end else begin
        fill_words();
        send_packet($urandom_range(1, MAX_HOPS), 8'($urandom), $urandom_range(0, MAX_WORDS),
                    $urandom_range(0, 2), 1'($urandom_range(0, 1)), -1);
        bus.req_valid = 1'b0;
        if ($urandom_range(0, 1) == 1) @(negedge clk);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
